// File: rtl/tt_pkg.sv
// tt_pkg: shared types and helpers for the truth-table equivalence engine.
//   sweep_state_t : sweep FSM states (IDLE, SWEEP, DONE)
//   tt_width()    : truth-table width for a given number of function inputs
//   lsb_index()   : index of the lowest set bit of a vector (0 when none set)
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // Largest supported table is 2**8 entries; helpers operate on that width.
  localparam int TT_MAX_W = 256;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  // Scanning from the top down leaves the lowest set index in r.
  function automatic int lsb_index(input logic [TT_MAX_W-1:0] v);
    int r;
    r = 0;
    for (int i = TT_MAX_W - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: exhaustive sweep of an external combinational netlist.
// Drives every input vector in turn, captures the responses into a table and
// compares it with the stored truth table when the sweep completes.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : single-cycle sweep request (honoured in IDLE only)
//   tt             : stored truth table to compare against
//   sweep_y        : netlist response to sweep_x (same cycle)
//   sweep_x        : vector currently driven to the netlist
//   busy           : high in SWEEP and DONE
//   done           : one-cycle pulse while in DONE
//   match          : captured table equals stored table
//   mism_idx       : lowest differing index, 0 when matched
//   cap            : captured table of the last completed sweep
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] tt,
  input  logic            sweep_y,
  output logic [N_IN-1:0] sweep_x,
  output logic            busy,
  output logic            done,
  output logic            match,
  output logic [N_IN-1:0] mism_idx,
  output logic [TT_W-1:0] cap
);

  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

  sweep_state_t            state;
  logic [N_IN-1:0]         idx;
  logic [TT_W-1:0]         cap_work;
  logic [TT_W-1:0]         cap_next;
  logic [TT_MAX_W-1:0]     diff_ext;

  // The final response arrives in the same cycle the FSM decides to enter
  // DONE, so the compare uses the working table with that bit merged in.
  always_comb begin
    cap_next      = cap_work;
    cap_next[idx] = sweep_y;
  end

  always_comb begin
    diff_ext            = '0;
    diff_ext[TT_W-1:0]  = cap_next ^ tt;
  end

  assign sweep_x = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cap_work <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      mism_idx <= '0;
      cap      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SWEEP;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        SWEEP: begin
          cap_work <= cap_next;
          if (idx == IDX_LAST) begin
            state    <= DONE;
            idx      <= '0;
            done     <= 1'b1;
            match    <= (cap_next == tt);
            mism_idx <= N_IN'(lsb_index(diff_ext));
            cap      <= cap_next;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tt_eqv_engine.sv
// tt_eqv_engine: programmable truth-table engine.
// Holds a 2**N_IN-bit truth table, evaluates vectors against it over a
// valid/ready stream, and runs exhaustive sweeps of an external netlist.
//   clk, rst                       : clock, asynchronous active-high reset
//   cfg_valid/cfg_ready/cfg_tt     : table load handshake (ready only in IDLE)
//   in_valid/in_ready/in_x         : eval vector stream
//   out_valid/out_ready/out_y      : eval result stream, f(in_x)
//   sweep_start                    : single-cycle sweep request
//   sweep_x/sweep_y                : vector to / response from the netlist
//   sweep_busy/sweep_done          : sweep in progress / result pulse
//   sweep_match/sweep_mism_idx/sweep_cap : result of last completed sweep
module tt_eqv_engine
  import tt_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [TT_W-1:0] cfg_tt,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_y,
  input  logic            sweep_start,
  output logic [N_IN-1:0] sweep_x,
  input  logic            sweep_y,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic            sweep_match,
  output logic [N_IN-1:0] sweep_mism_idx,
  output logic [TT_W-1:0] sweep_cap
);

  logic [TT_W-1:0] tt_reg;
  logic            accept_p0;
  logic            y_p1;
  logic            vld_p1;

  // busy is registered high exactly in SWEEP and DONE, so its inverse is IDLE.
  assign cfg_ready = !sweep_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_reg <= '0;
    end else if (cfg_valid && cfg_ready) begin
      tt_reg <= cfg_tt;
    end
  end

  // Stage p0 -> p1: table lookup. A load on the same edge is not yet visible.
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      y_p1   <= 1'b0;
    end else if (accept_p0) begin
      vld_p1 <= 1'b1;
      y_p1   <= tt_reg[in_x];
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_y     = y_p1;

  tt_sweep_ctrl #(
    .N_IN(N_IN)
  ) u_sweep (
    .clk      (clk),
    .rst      (rst),
    .start    (sweep_start),
    .tt       (tt_reg),
    .sweep_y  (sweep_y),
    .sweep_x  (sweep_x),
    .busy     (sweep_busy),
    .done     (sweep_done),
    .match    (sweep_match),
    .mism_idx (sweep_mism_idx),
    .cap      (sweep_cap)
  );

endmodule

// File: tb/tb_tt_eqv_engine.sv
module tb_tt_eqv_engine;

  localparam int N_IN = 4;
  localparam int TT_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [TT_W-1:0] cfg_tt;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_x;
  logic            out_valid;
  logic            out_ready;
  logic            out_y;
  logic            sweep_start;
  logic [N_IN-1:0] sweep_x;
  logic            sweep_y;
  logic            sweep_busy;
  logic            sweep_done;
  logic            sweep_match;
  logic [N_IN-1:0] sweep_mism_idx;
  logic [TT_W-1:0] sweep_cap;

  int errors = 0;
  int checks = 0;

  // Behavioural view: the table the engine should hold and the gate netlist.
  logic [TT_W-1:0] tt_cur;
  logic [TT_W-1:0] net_tt;

  assign sweep_y = net_tt[sweep_x];

  always #5 clk = ~clk;

  tt_eqv_engine #(.N_IN(N_IN)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_tt         (cfg_tt),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_x           (in_x),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_y          (out_y),
    .sweep_start    (sweep_start),
    .sweep_x        (sweep_x),
    .sweep_y        (sweep_y),
    .sweep_busy     (sweep_busy),
    .sweep_done     (sweep_done),
    .sweep_match    (sweep_match),
    .sweep_mism_idx (sweep_mism_idx),
    .sweep_cap      (sweep_cap)
  );

  typedef struct {
    logic [N_IN-1:0] x;
    logic            y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int low_diff(input logic [TT_W-1:0] a, input logic [TT_W-1:0] b);
    for (int i = 0; i < TT_W; i++) begin
      if (a[i] != b[i]) return i;
    end
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"},   32'(cfg_ready), 32'd1);
    check({tag, "_out_valid"},   32'(out_valid), 32'd0);
    check({tag, "_out_y"},       32'(out_y), 32'd0);
    check({tag, "_sweep_x"},     32'(sweep_x), 32'd0);
    check({tag, "_sweep_busy"},  32'(sweep_busy), 32'd0);
    check({tag, "_sweep_done"},  32'(sweep_done), 32'd0);
    check({tag, "_sweep_match"}, 32'(sweep_match), 32'd0);
    check({tag, "_mism_idx"},    32'(sweep_mism_idx), 32'd0);
    check({tag, "_sweep_cap"},   32'(sweep_cap), 32'd0);
  endtask

  task automatic load_tt(input logic [TT_W-1:0] v);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_tt    = v;
    @(negedge clk);
    cfg_valid = 1'b0;
    tt_cur    = v;
  endtask

  // mode 0: plain sweep, 1: cfg/start collision on cycle 5, 2: reset on cycle 7
  task automatic do_sweep(input logic [TT_W-1:0] net, input int mode);
    int done_cnt;
    int done_at;
    logic [TT_W-1:0] tt_before;
    done_cnt  = 0;
    done_at   = -1;
    tt_before = tt_cur;
    net_tt    = net;
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int c = 1; c <= TT_W + 4; c++) begin
      if (mode == 2 && c == 7) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst    = 1'b0;
        tt_cur = '0;
        for (int k = 0; k < TT_W + 4; k++) begin
          if (sweep_done) done_cnt++;
          @(negedge clk);
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        return;
      end
      if (c <= TT_W) begin
        check("sweep_x", 32'(sweep_x), 32'(c - 1));
        check("sweep_busy", 32'(sweep_busy), 32'd1);
        check("cfg_ready_busy", 32'(cfg_ready), 32'd0);
      end
      if (sweep_done) begin
        done_cnt++;
        done_at = c;
        check("sweep_busy_done", 32'(sweep_busy), 32'd1);
        check("sweep_match", 32'(sweep_match), 32'(net == tt_cur));
        check("sweep_cap", 32'(sweep_cap), 32'(net));
        check("sweep_mism_idx", 32'(sweep_mism_idx), 32'(low_diff(net, tt_cur)));
      end
      if (mode == 1 && c == 5) begin
        cfg_valid   = 1'b1;
        cfg_tt      = ~tt_cur;
        sweep_start = 1'b1;
      end
      if (mode == 1 && c == 6) begin
        cfg_valid   = 1'b0;
        sweep_start = 1'b0;
      end
      if (c == TT_W + 2) begin
        check("idle_busy", 32'(sweep_busy), 32'd0);
        check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        check("held_cap", 32'(sweep_cap), 32'(net));
        check("held_match", 32'(sweep_match), 32'(net == tt_cur));
      end
      @(negedge clk);
    end
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_at), 32'(TT_W + 1));
    if (mode == 1) check("tt_unchanged", 32'(tt_cur), 32'(tt_before));
  endtask

  initial begin
    vec_t vt[6];
    logic q[$];
    logic [TT_W-1:0] rnd_tt;
    logic [TT_W-1:0] rnd_net;
    logic exp_y;

    vt[0] = '{4'd0,  1'b0};
    vt[1] = '{4'd1,  1'b1};
    vt[2] = '{4'd2,  1'b1};
    vt[3] = '{4'd3,  1'b0};
    vt[4] = '{4'd8,  1'b1};
    vt[5] = '{4'd15, 1'b0};

    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_tt = '0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b1;
    sweep_start = 1'b0;
    net_tt = '0;
    tt_cur = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Load 0x7176 and stream the table vectors back to back.
    load_tt(16'h7176);
    in_valid = 1'b1;
    in_x     = vt[0].x;
    for (int i = 0; i < 6; i++) begin
      check("stream_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("stream_out_valid", 32'(out_valid), 32'd1);
      check("stream_out_y", 32'(out_y), 32'(vt[i].y));
      if (i < 5) in_x = vt[i + 1].x;
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_drain", 32'(out_valid), 32'd0);

    // Back-pressure: first result held while out_ready is low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 4'd1;
    @(negedge clk);
    in_x = 4'd3;
    for (int k = 0; k < 3; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_y", 32'(out_y), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      if (k < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_y", 32'(out_y), 32'd0);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Sweep matching and mismatching netlists.
    do_sweep(16'h7176, 0);
    do_sweep(16'h7176 ^ 16'h0200, 0);
    check("mism_cap_value", 32'(sweep_cap), 32'h7376);
    check("mism_idx_value", 32'(sweep_mism_idx), 32'd9);

    // Collision during a sweep, then confirm the table via eval.
    do_sweep(16'h7176, 1);
    in_valid = 1'b1;
    in_x     = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_collision_eval", 32'(out_y), 32'd1);

    // Mid-sweep reset, then a fresh sweep.
    do_sweep(16'h7176, 2);
    load_tt(16'h7176);
    do_sweep(16'h7176, 0);

    // Load and start in the same IDLE cycle: DONE compares against new table.
    net_tt = 16'hA5C3;
    @(negedge clk);
    cfg_valid   = 1'b1;
    cfg_tt      = 16'hA5C3;
    sweep_start = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
    sweep_start = 1'b0;
    tt_cur      = 16'hA5C3;
    repeat (TT_W) @(negedge clk);
    check("same_cycle_done", 32'(sweep_done), 32'd1);
    check("same_cycle_match", 32'(sweep_match), 32'd1);
    @(negedge clk);

    // Random sweeps against a lowest-difference model.
    for (int r = 0; r < 3; r++) begin
      rnd_tt  = 16'($urandom);
      rnd_net = (r == 0) ? rnd_tt : rnd_tt ^ (16'h1 << $urandom_range(15, 0)) ^ 16'($urandom & 32'h8000);
      load_tt(rnd_tt);
      do_sweep(rnd_net, 0);
    end

    // Random eval traffic with table reloads; reference is a result queue.
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      check("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("rnd_out_y", 32'(out_y), 32'(q[0]));
      in_valid  = 1'($urandom);
      in_x      = 4'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      cfg_valid = ($urandom_range(15, 0) == 0);
      cfg_tt    = 16'($urandom);
      #1;
      check("rnd_in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
      exp_y = tt_cur[in_x];
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && (q.size() == 0)) q.push_back(exp_y);
      if (cfg_valid) tt_cur = cfg_tt;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
